// File: rtl/rv32_pkg.sv
// Shared RV32I constants for the MEM-stage blocks.
// funct3 encodings for load/store width and signedness.
package rv32_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word from a memory word and
// sign- or zero-extends it to 32 bits according to funct3.
module load_extend
  import rv32_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_sel,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = 8'h00;
    half_val = 16'h0000;
    result   = 32'h0;
    case (byte_sel)
      2'd0: byte_val = word[7:0];
      2'd1: byte_val = word[15:8];
      2'd2: byte_val = word[23:16];
      default: byte_val = word[31:24];
    endcase
    // half-word lane ignores the low address bit
    half_val = byte_sel[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_val[7]}}, byte_val};
      F3_BU:   result = {24'h0, byte_val};
      F3_H:    result = {{16{half_val[15]}}, half_val};
      F3_HU:   result = {16'h0, half_val};
      F3_W:    result = word;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data RAM: clocked SB/SH/SW stores,
// combinational LB/LH/LW/LBU/LHU loads with read-before-write behaviour.
module data_memory
  import rv32_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  localparam int ADDR_LSB = 2;
  localparam int IDX_W    = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [3:0]       byte_en;
  logic [31:0]      lane_data;
  logic [31:0]      load_val;
  logic             unused_addr;

  assign idx         = addr[ADDR_LSB+IDX_W-1:ADDR_LSB];
  assign unused_addr = ^addr[31:ADDR_LSB+IDX_W];

  // store data is replicated across lanes; byte_en picks which lanes land
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = 32'h0;
    case (funct3)
      F3_B: begin
        byte_en   = 4'b0001 << addr[1:0];
        lane_data = {4{write_data[7:0]}};
      end
      F3_H: begin
        byte_en   = addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{write_data[15:0]}};
      end
      F3_W: begin
        byte_en   = 4'b1111;
        lane_data = write_data;
      end
      default: begin
        byte_en   = 4'b0000;
        lane_data = 32'h0;
      end
    endcase
  end

  // array contents are deliberately not cleared by rst
  always_ff @(posedge clk) begin
    if (!rst && mem_write) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
  end

  load_extend u_load_extend (
    .word     (mem[idx]),
    .byte_sel (addr[1:0]),
    .funct3   (funct3),
    .result   (load_val)
  );

  assign read_data = (mem_read && !rst) ? load_val : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus random
// loads/stores checked against a byte-array reference model.
module tb_data_memory;

  localparam int DEPTH_WORDS = 256;
  localparam int NBYTES      = 4 * DEPTH_WORDS;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_mem [NBYTES];

  data_memory #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int b;
    b = int'(a % NBYTES);
    case (f3)
      3'b000: model_mem[b] = d[7:0];
      3'b001: begin
        b = b - (b % 2);
        model_mem[b]   = d[7:0];
        model_mem[b+1] = d[15:8];
      end
      3'b010: begin
        b = b - (b % 4);
        for (int i = 0; i < 4; i++) model_mem[b+i] = d[8*i +: 8];
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int b, h, w;
    logic [15:0] hv;
    b  = int'(a % NBYTES);
    h  = b - (b % 2);
    w  = b - (b % 4);
    hv = {model_mem[h+1], model_mem[h]};
    case (f3)
      3'b000: return 32'($signed(model_mem[b]));
      3'b100: return {24'h0, model_mem[b]};
      3'b001: return 32'($signed(hv));
      3'b101: return {16'h0, hv};
      3'b010: return {model_mem[w+3], model_mem[w+2], model_mem[w+1], model_mem[w]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; funct3 = f3; addr = a; write_data = d;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    model_store(f3, a, d);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a;
    #1;
    check(tag, read_data, exp);
    check({tag, "_model"}, read_data, model_load(f3, a));
    mem_read = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = 3'b010; addr = 32'h0; write_data = 32'h0;
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
    @(negedge clk);
    check("reset_read", read_data, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;

    for (int w = 0; w < DEPTH_WORDS; w++) store(3'b010, 32'(4 * w), 32'h0);

    store(3'b010, 32'h0, 32'hDEADBEEF);
    load("lw_0", 3'b010, 32'h0, 32'hDEADBEEF);
    store(3'b000, 32'h1, 32'h000000AA);
    load("lw_after_sb", 3'b010, 32'h0, 32'hDEADAAEF);
    load("lb_1", 3'b000, 32'h1, 32'hFFFFFFAA);
    load("lbu_1", 3'b100, 32'h1, 32'h000000AA);
    store(3'b001, 32'h2, 32'h0000BEEF);
    load("lh_2", 3'b001, 32'h2, 32'hFFFFBEEF);
    load("lhu_2", 3'b101, 32'h2, 32'h0000BEEF);
    load("lhu_3", 3'b101, 32'h3, 32'h0000BEEF);
    load("lw_after_sh", 3'b010, 32'h0, 32'hBEEFAAEF);
    store(3'b010, 32'h4, 32'h12345678);
    load("lw_4", 3'b010, 32'h4, 32'h12345678);
    load("lw_0_kept", 3'b010, 32'h0, 32'hBEEFAAEF);
    load("lw_unaligned", 3'b010, 32'h7, 32'h12345678);

    // reset suppresses stores and forces zero reads
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
    funct3 = 3'b010; addr = 32'h4; write_data = 32'hFFFFFFFF;
    #1;
    check("rst_read_zero", read_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    load("lw_after_rst", 3'b010, 32'h4, 32'h12345678);

    store(3'b011, 32'h0, 32'hCAFEF00D);
    load("f3_011_nowrite", 3'b010, 32'h0, 32'hBEEFAAEF);
    load("alias_word0", 3'b010, 32'(NBYTES), 32'hBEEFAAEF);
    load("ld_f3_011", 3'b011, 32'h0, 32'h0);
    load("ld_f3_110", 3'b110, 32'h4, 32'h0);

    @(negedge clk);
    mem_read = 1'b0; funct3 = 3'b010; addr = 32'h0;
    #1;
    check("read_disabled", read_data, 32'h0);

    // read-before-write: same cycle shows old word, next cycle shows new
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h4; write_data = 32'hA5A5_5A5A;
    #1;
    check("rbw_old", read_data, 32'h12345678);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    model_store(3'b010, 32'h4, 32'hA5A5_5A5A);
    check("rbw_new", read_data, 32'hA5A5_5A5A);
    mem_read = 1'b0;

    for (int it = 0; it < 400; it++) begin
      logic [2:0]  f3;
      logic [31:0] a, d;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 4 * NBYTES - 1);
      d  = $urandom;
      if ($urandom_range(0, 1) == 0) store(f3, a, d);
      else begin
        @(negedge clk);
        mem_read = 1'b1; funct3 = f3; addr = a;
        #1;
        check("rand_load", read_data, model_load(f3, a));
        mem_read = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
